// File: rtl/imem_loader_if.sv
// -----------------------------------------------------------------------------
// imem_loader_if
//   Byte-stream handshake into the instruction-memory loader.
//   A byte moves on a clock edge where in_valid and in_ready are both high.
//
//   in_valid : source -> loader, in_data holds a valid byte
//   in_data  : source -> loader, stream byte
//   in_ready : loader -> source, loader accepts a byte this cycle
//
//   modport master : byte source (e.g. UART receiver)
//   modport slave  : imem_loader
// -----------------------------------------------------------------------------
interface imem_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Writer side of the instruction memory. Receives a program as a byte
//   stream, assembles little-endian 32-bit words and stores them sequentially
//   in an internal RAM. The core is held in reset until the whole program has
//   been loaded; it fetches through a combinational word-aligned read port.
//
//   Stream format: count[7:0], count[15:8], then count words of 4 bytes each,
//   least significant byte first. Valid counts are 1..DEPTH.
//
//   Ports:
//     clk          : clock
//     reset        : asynchronous, active-high reset
//     start        : single-cycle pulse, begins a load session
//     stream       : byte-stream handshake (imem_loader_if.slave)
//     core_reset   : high holds the core (PC register) in reset
//     done         : program loaded, core running
//     error        : malformed session, core held
//     words_loaded : words written in the current session
//     pc_addr      : core fetch byte address
//     instr        : instruction word at pc_addr (combinational)
//
//   Build option:
//     IMEM_LOADER_CHECKSUM_EN : when defined, one extra byte follows the last
//     data word and must equal the XOR of all data bytes; otherwise the
//     session ends in error.
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  imem_loader_if.slave  stream,
  output logic          core_reset,
  output logic          done,
  output logic          error,
  output logic [15:0]   words_loaded,
  input  logic [31:0]   pc_addr,
  output logic [31:0]   instr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR0,
    S_HDR1,
    S_DATA,
    S_DONE,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_ERROR
  } state_t;

  state_t state, state_next;

  logic [15:0] count;
  logic [1:0]  byte_idx;
  logic [23:0] word_buf;     // bytes 0..2 of the word being assembled
  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        last_byte;
  logic        word_we;
  logic        start_edge;
  logic [15:0] words_next;
  logic [15:0] hdr_count;
  logic        hdr_bad;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  // ---------------------------------------------------------------------------
  // Handshake and datapath decode
  // ---------------------------------------------------------------------------
  assign accept     = stream.in_valid & stream.in_ready;
  assign last_byte  = (byte_idx == 2'd3);
  assign words_next = words_loaded + 16'd1;
  assign word_we    = (state == S_DATA) && accept && last_byte;

  // Full count is formed from the held low byte and the byte on the bus, so
  // the range check happens on the same edge that accepts the high byte.
  assign hdr_count  = {stream.in_data, count[7:0]};
  assign hdr_bad    = (hdr_count == 16'd0) || (32'(hdr_count) > DEPTH);

  // start only has an effect in the states that wait for a new session.
  assign start_edge = start &&
                      ((state == S_IDLE) || (state == S_DONE) || (state == S_ERROR));

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next state and state-decoded outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    stream.in_ready = 1'b0;
    core_reset      = 1'b1;
    done            = 1'b0;
    error           = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) state_next = S_HDR0;
      end

      S_HDR0: begin
        stream.in_ready = 1'b1;
        if (accept) state_next = S_HDR1;
      end

      S_HDR1: begin
        stream.in_ready = 1'b1;
        if (accept) state_next = hdr_bad ? S_ERROR : S_DATA;
      end

      S_DATA: begin
        stream.in_ready = 1'b1;
        if (word_we && (words_next == count)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CSUM;
`else
          state_next = S_DONE;
`endif
        end
      end

`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CSUM: begin
        stream.in_ready = 1'b1;
        if (accept) state_next = (stream.in_data == csum) ? S_DONE : S_ERROR;
      end
`endif

      S_DONE: begin
        core_reset = 1'b0;
        done       = 1'b1;
        if (start) state_next = S_HDR0;
      end

      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_HDR0;
      end

      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Session datapath: header count, word assembly, progress counter
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count        <= '0;
      words_loaded <= '0;
      byte_idx     <= '0;
      word_buf     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      if (start_edge) begin
        words_loaded <= '0;
        byte_idx     <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum         <= '0;
`endif
      end

      if ((state == S_HDR0) && accept) begin
        count[7:0] <= stream.in_data;
      end

      if ((state == S_HDR1) && accept) begin
        count        <= hdr_count;
        words_loaded <= '0;
        byte_idx     <= '0;
      end

      if ((state == S_DATA) && accept) begin
        byte_idx <= byte_idx + 2'd1;   // wraps to 0 after the 4th byte
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum     <= csum ^ stream.in_data;
`endif
        unique case (byte_idx)
          2'd0: word_buf[7:0]   <= stream.in_data;
          2'd1: word_buf[15:8]  <= stream.in_data;
          2'd2: word_buf[23:16] <= stream.in_data;
          2'd3: words_loaded    <= words_next;
          default: ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Instruction RAM: not reset, written on the edge accepting a word's 4th byte
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (word_we) begin
      mem[words_loaded[ADDR_W-1:0]] <= {stream.in_data, word_buf};
    end
  end

  // Word-aligned fetch; byte offset and upper address bits wrap away.
  assign instr = mem[pc_addr[ADDR_W+1:2]];

  logic unused_pc_bits;
  assign unused_pc_bits = ^{pc_addr[31:ADDR_W+2], pc_addr[1:0]};

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//   Scoreboard bench for imem_loader. Expected session outcomes and expected
//   fetch words are queued by the stimulus process; a monitor pops and
//   compares them when the DUT raises done/error or a fetch is presented.
// -----------------------------------------------------------------------------
module tb_imem_loader;
  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        core_reset;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;
  logic [31:0] pc_addr;
  logic [31:0] instr;

  imem_loader_if bus ();

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .stream       (bus),
    .core_reset   (core_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded),
    .pc_addr      (pc_addr),
    .instr        (instr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic        done;
    logic        error;
    logic [15:0] words;
  } sess_t;

  sess_t       sess_q[$];
  logic [31:0] rd_q[$];
  logic [7:0]  tx[$];
  logic [7:0]  csum_acc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor: session outcome on rising done/error, fetch word when queued
  // ---------------------------------------------------------------------------
  logic  prev_done  = 1'b0;
  logic  prev_error = 1'b0;
  sess_t mon_e;

  always @(negedge clk) begin
    if ((done && !prev_done) || (error && !prev_error)) begin
      if (sess_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL session_unexpected actual done=%0d error=%0d required none", done, error);
      end else begin
        mon_e = sess_q.pop_front();
        chk("session_done", 32'(done), 32'(mon_e.done));
        chk("session_error", 32'(error), 32'(mon_e.error));
        chk("session_words", 32'(words_loaded), 32'(mon_e.words));
        chk("session_core_reset", 32'(core_reset), 32'(!mon_e.done));
      end
    end
    prev_done  = done;
    prev_error = error;
    if (rd_q.size() != 0) begin
      chk($sformatf("instr@0x%08h", pc_addr), instr, rd_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic hdr(input logic [15:0] cnt);
    tx.delete();
    csum_acc = 8'h00;
    tx.push_back(cnt[7:0]);
    tx.push_back(cnt[15:8]);
  endtask

  task automatic dat(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      tx.push_back(w[8*i +: 8]);
      csum_acc = csum_acc ^ w[8*i +: 8];
    end
  endtask

  task automatic tail();
`ifdef IMEM_LOADER_CHECKSUM_EN
    tx.push_back(csum_acc);
`endif
  endtask

  task automatic start_pulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer every byte of tx in order; optionally insert idle gaps and pulse
  // start together with byte index start_at.
  task automatic send_bytes(input bit stall, input int start_at);
    for (int k = 0; k < tx.size(); k++) begin
      if (stall && ($urandom_range(0, 2) == 0)) begin
        bus.in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) begin
          @(posedge clk); #1;
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = tx[k];
      start        = (k == start_at);
      begin
        bit took = 1'b0;
        int n    = 0;
        while (!took) begin
          took = bus.in_ready;
          @(posedge clk); #1;
          start = 1'b0;
          n++;
          if (!took && n > 50) begin
            checks++;
            failures++;
            $display("FAIL byte_timeout actual in_ready=0 required 1 (byte %0d)", k);
            break;
          end
        end
      end
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [31:0] exp);
    pc_addr = addr;
    rd_q.push_back(exp);
    @(negedge clk); #1;
    if (rd_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL rd_timeout actual pending=%0d required 0", rd_q.size());
      rd_q.delete();
    end
  endtask

  task automatic prog1();
    hdr(16'd3);
    dat(32'h0000_0513);
    dat(32'h0010_0593);
    dat(32'h0000_006F);
    tail();   // XOR of these 12 data bytes is 0xFF
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    pc_addr      = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_core_reset", 32'(core_reset), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_error", 32'(error), 32'd0);
    chk("rst_words", 32'(words_loaded), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Bytes offered in IDLE are refused
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hAA;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("idle_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;

    // Basic load, in_valid held high
    start_pulse();
    chk("hdr0_in_ready", 32'(bus.in_ready), 32'd1);
    prog1();
    sess_q.push_back('{done: 1'b1, error: 1'b0, words: 16'd3});
    send_bytes(1'b0, -1);
    chk("basic_done", 32'(done), 32'd1);
    chk("basic_core_reset", 32'(core_reset), 32'd0);
    chk("basic_words", 32'(words_loaded), 32'd3);
    chk("basic_in_ready", 32'(bus.in_ready), 32'd0);
    rd(32'd0, 32'h0000_0513);
    rd(32'd4, 32'h0010_0593);
    rd(32'd8, 32'h0000_006F);
    rd(32'd8 + 32'd256, 32'h0000_006F);
    rd(32'd11, 32'h0000_006F);
    rd(32'hFFFF_FF04, 32'h0010_0593);

    // Bad header: zero count
    start_pulse();
    hdr(16'd0);
    sess_q.push_back('{done: 1'b0, error: 1'b1, words: 16'd0});
    send_bytes(1'b0, -1);
    chk("hdr0_error", 32'(error), 32'd1);
    chk("hdr0_err_in_ready", 32'(bus.in_ready), 32'd0);
    chk("hdr0_err_core_reset", 32'(core_reset), 32'd1);

    // Bad header: 65 > DEPTH
    start_pulse();
    chk("err_start_clears", 32'(error), 32'd0);
    hdr(16'd65);
    sess_q.push_back('{done: 1'b0, error: 1'b1, words: 16'd0});
    send_bytes(1'b0, -1);
    chk("hdr65_error", 32'(error), 32'd1);
    chk("hdr65_core_reset", 32'(core_reset), 32'd1);

    // Maximum count (DEPTH words), start pulsed mid-DATA is ignored
    start_pulse();
    hdr(16'd64);
    for (int i = 0; i < 64; i++) dat(32'hA500_0000 | 32'(i));
    tail();
    sess_q.push_back('{done: 1'b1, error: 1'b0, words: 16'd64});
    send_bytes(1'b0, 10);
    chk("full_error", 32'(error), 32'd0);
    chk("full_done", 32'(done), 32'd1);
    rd(32'd252, 32'hA500_003F);
    rd(32'd0, 32'hA500_0000);

    // start in DONE re-holds the core; single-word reload
    start_pulse();
    chk("restart_core_reset", 32'(core_reset), 32'd1);
    chk("restart_done", 32'(done), 32'd0);
    chk("restart_words", 32'(words_loaded), 32'd0);
    hdr(16'd1);
    dat(32'hDEAD_BEEF);
    tail();
    sess_q.push_back('{done: 1'b1, error: 1'b0, words: 16'd1});
    send_bytes(1'b0, -1);
    chk("beef_done", 32'(done), 32'd1);
    rd(32'd0, 32'hDEAD_BEEF);
    rd(32'd4, 32'hA500_0001);

    // Reset in the middle of DATA: one word written, two bytes of the next
    start_pulse();
    hdr(16'd3);
    dat(32'h1122_3344);
    tx.push_back(8'h66);
    tx.push_back(8'h55);
    send_bytes(1'b0, -1);
    chk("mid_words", 32'(words_loaded), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("arst_core_reset", 32'(core_reset), 32'd1);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_words", 32'(words_loaded), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    rd(32'd0, 32'h1122_3344);
    rd(32'd4, 32'hA500_0001);

    // Stalled stream, with bytes already offered in IDLE before start
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h13;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("idle2_in_ready", 32'(bus.in_ready), 32'd0);
    start_pulse();
    prog1();
    sess_q.push_back('{done: 1'b1, error: 1'b0, words: 16'd3});
    send_bytes(1'b1, -1);
    chk("stall_done", 32'(done), 32'd1);
    chk("stall_core_reset", 32'(core_reset), 32'd0);
    chk("stall_words", 32'(words_loaded), 32'd3);
    rd(32'd0, 32'h0000_0513);
    rd(32'd4, 32'h0010_0593);
    rd(32'd8, 32'h0000_006F);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Wrong checksum byte
    start_pulse();
    prog1();
    void'(tx.pop_back());
    tx.push_back(8'h00);
    sess_q.push_back('{done: 1'b0, error: 1'b1, words: 16'd3});
    send_bytes(1'b0, -1);
    chk("csum_error", 32'(error), 32'd1);
    chk("csum_core_reset", 32'(core_reset), 32'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sess_q_drained", 32'(sess_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
